stepper_ramp_axis: RTL and testbench

STEPPER_RAMP_AXIS -- requirements
Module: stepper_ramp_axis

---
 rtl/stepper_pkg.sv | 30 +++
 rtl/step_pulse_timer.sv | 71 +++++++
 rtl/stepper_ramp_axis.sv | 216 +++++++++++++++++++++
 tb/tb_stepper_ramp_axis.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Package  : stepper_pkg
// Desc     : Shared state encoding and default timing constants for the
//            stepper ramp axis.
// Revision : 1.0 - initial release
// ============================================================================
package stepper_pkg;

    // Default minimum step high/low width: 1 us at 50 MHz
    localparam int unsigned c_MIN_PULSE_DEF = 50;
    // Default dir-to-first-step setup time: 200 ns at 50 MHz
    localparam int unsigned c_SETUP_CYC_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCEL  = 3'd2,
        ST_CRUISE = 3'd3,
        ST_DECEL  = 3'd4,
        ST_DONE   = 3'd5
    } stepper_state_e;

    // True in the states where step pulses are being generated
    function automatic logic is_motion(input stepper_state_e s);
        return (s == ST_ACCEL) || (s == ST_CRUISE) || (s == ST_DECEL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_timer
// Desc     : Loadable period counter. A load starts a new period with step
//            high; step drops after the high time and the boundary strobe
//            marks the last cycle of the period. Everything freezes while
//            enable is low.
// Revision : 1.0 - initial release
// ============================================================================
module step_pulse_timer #(
    parameter int unsigned CNT_W     = 25,
    parameter int unsigned MIN_PULSE = 50
)(
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    output logic             step,
    output logic             boundary
);

    localparam logic [CNT_W-1:0] c_MIN_HIGH = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_high;
    logic             r_run;
    logic             r_step;

    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_high_ld;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_half    = period >> 1;
    assign w_high_ld = (w_half < c_MIN_HIGH) ? c_MIN_HIGH : w_half;
    assign w_cnt_inc = r_cnt + c_ONE;

    // Boundary is only reported on a cycle that actually advances the count
    assign boundary = r_run && enable && (r_cnt == (r_per - c_ONE));
    assign step     = r_step;

    // Period counter and registered step output
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_per  <= '0;
            r_high <= '0;
            r_run  <= 1'b0;
            r_step <= 1'b0;
        end else if (load) begin
            r_cnt  <= '0;
            r_per  <= period;
            r_high <= w_high_ld;
            r_run  <= 1'b1;
            r_step <= 1'b1;
        end else if (r_run && enable) begin
            if (boundary) begin
                r_cnt  <= '0;
                r_run  <= 1'b0;
                r_step <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_step <= (w_cnt_inc < r_high);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stepper_ramp_axis.sv
`default_nettype none
// ============================================================================
// Module   : stepper_ramp_axis
// Desc     : Single-axis stepper pulse generator with a trapezoidal
//            (or triangular) period ramp, pause and graceful abort.
// Revision : 1.0 - initial release
// ============================================================================
module stepper_ramp_axis
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_W    = 16,
    parameter int unsigned PER_W     = 24,
    parameter int unsigned MIN_PULSE = c_MIN_PULSE_DEF,
    parameter int unsigned SETUP_CYC = c_SETUP_CYC_DEF
)(
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [PER_W-1:0]  cmd_start_per,
    input  logic [PER_W-1:0]  cmd_cruise_per,
    input  logic [PER_W-1:0]  cmd_accel,
    input  logic              enable,
    input  logic              abort,
    output logic              step,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_done
);

    // One spare bit so cur_per +/- accel can never wrap before saturation
    localparam int unsigned c_PW      = PER_W + 1;
    localparam int unsigned c_SETUP_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    localparam logic [c_PW-1:0]      c_MIN_PER    = c_PW'(2 * MIN_PULSE);
    localparam logic [c_SETUP_W-1:0] c_SETUP_LAST = c_SETUP_W'(SETUP_CYC - 1);
    localparam logic [c_SETUP_W-1:0] c_SETUP_ONE  = c_SETUP_W'(1);
    localparam logic [STEP_W-1:0]    c_STEP_ONE   = STEP_W'(1);

    stepper_state_e         r_state;
    logic [STEP_W-1:0]      r_steps;
    logic [c_PW-1:0]        r_start;
    logic [c_PW-1:0]        r_cruise;
    logic [c_PW-1:0]        r_accel;
    logic [c_PW-1:0]        r_cur;
    logic [STEP_W-1:0]      r_ramp;
    logic [STEP_W-1:0]      r_steps_done;
    logic [c_SETUP_W-1:0]   r_setup_cnt;
    logic                   r_dir;
    logic                   r_abort_pend;

    stepper_state_e         w_state_nx;
    logic                   w_accept;
    logic                   w_load;
    logic [c_PW-1:0]        w_cur_nx;
    logic [STEP_W-1:0]      w_ramp_nx;
    logic [STEP_W-1:0]      w_sd_nx;
    logic [STEP_W-1:0]      w_sd_inc;
    logic [STEP_W-1:0]      w_remaining;
    logic [STEP_W-1:0]      w_ramp_inc;
    logic [c_PW-1:0]        w_cruise_c;
    logic [c_PW-1:0]        w_start_ext;
    logic [c_PW-1:0]        w_start_c;
    logic [c_PW-1:0]        w_floor;
    logic [c_PW-1:0]        w_per_dn;
    logic [c_PW-1:0]        w_sum_up;
    logic [c_PW-1:0]        w_per_up;
    logic                   w_bnd;
    logic                   w_tmr_step;
    logic                   w_stop_req;

    // Clamp the offered periods: cruise >= 2*MIN_PULSE, start >= cruise
    assign w_cruise_c  = ({1'b0, cmd_cruise_per} < c_MIN_PER) ? c_MIN_PER
                                                              : {1'b0, cmd_cruise_per};
    assign w_start_ext = {1'b0, cmd_start_per};
    assign w_start_c   = (w_start_ext < w_cruise_c) ? w_cruise_c : w_start_ext;

    assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
    assign w_stop_req  = abort || r_abort_pend;

    // Step bookkeeping as seen at the boundary currently being evaluated
    assign w_sd_inc    = r_steps_done + c_STEP_ONE;
    assign w_remaining = r_steps - w_sd_inc;
    assign w_ramp_inc  = (r_state == ST_ACCEL) ? (r_ramp + c_STEP_ONE) : r_ramp;

    // Saturating period arithmetic; r_cur >= r_cruise always holds
    assign w_floor  = r_cruise + r_accel;
    assign w_per_dn = (r_cur >= w_floor) ? (r_cur - r_accel) : r_cruise;
    assign w_sum_up = r_cur + r_accel;
    assign w_per_up = (w_sum_up > r_start) ? r_start : w_sum_up;

    // Next-state, next-period and timer-load decode
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_cur_nx   = r_cur;
        w_ramp_nx  = r_ramp;
        w_sd_nx    = r_steps_done;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_state_nx = ST_SETUP;
            end
            ST_SETUP: begin
                if (enable) begin
                    if (w_stop_req) begin
                        w_state_nx = ST_DONE;
                    end else if (r_setup_cnt == c_SETUP_LAST) begin
                        if (r_steps == '0) begin
                            w_state_nx = ST_DONE;
                        end else begin
                            w_state_nx = ST_ACCEL;
                            w_load     = 1'b1;
                            w_cur_nx   = r_start;
                            w_ramp_nx  = '0;
                        end
                    end
                end
            end
            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                if (w_bnd) begin
                    w_sd_nx = w_sd_inc;
                    if ((w_sd_inc == r_steps) || w_stop_req) begin
                        // Final or aborted pulse has completed its low time
                        w_state_nx = ST_DONE;
                    end else begin
                        w_load = 1'b1;
                        if (r_state == ST_DECEL) begin
                            w_cur_nx = w_per_up;
                        end else if (w_remaining <= w_ramp_inc) begin
                            // Just enough steps left to ramp back down
                            w_state_nx = ST_DECEL;
                            w_cur_nx   = w_per_up;
                        end else if (r_state == ST_ACCEL) begin
                            w_cur_nx  = w_per_dn;
                            w_ramp_nx = w_ramp_inc;
                            if (w_per_dn == r_cruise) w_state_nx = ST_CRUISE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Command latch, FSM state and motion counters
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_steps      <= '0;
            r_start      <= '0;
            r_cruise     <= '0;
            r_accel      <= '0;
            r_cur        <= '0;
            r_ramp       <= '0;
            r_steps_done <= '0;
            r_setup_cnt  <= '0;
            r_dir        <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_steps      <= cmd_steps;
                r_start      <= w_start_c;
                r_cruise     <= w_cruise_c;
                r_accel      <= {1'b0, cmd_accel};
                r_cur        <= '0;
                r_ramp       <= '0;
                r_steps_done <= '0;
                r_setup_cnt  <= '0;
                r_dir        <= cmd_dir;
                r_abort_pend <= 1'b0;
            end else begin
                r_cur        <= w_cur_nx;
                r_ramp       <= w_ramp_nx;
                r_steps_done <= w_sd_nx;
                if ((r_state == ST_SETUP) && enable) begin
                    r_setup_cnt <= r_setup_cnt + c_SETUP_ONE;
                end
                // Remember an abort until the current period can end cleanly
                if (abort && ((r_state == ST_SETUP) || is_motion(r_state))) begin
                    r_abort_pend <= 1'b1;
                end
            end
        end
    end

    step_pulse_timer #(
        .CNT_W     (c_PW),
        .MIN_PULSE (MIN_PULSE)
    ) u_timer (
        .clk_50   (clk_50),
        .reset_n  (reset_n),
        .enable   (enable),
        .load     (w_load),
        .period   (w_cur_nx),
        .step     (w_tmr_step),
        .boundary (w_bnd)
    );

    assign step       = w_tmr_step;
    assign dir        = r_dir;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign cmd_ready  = (r_state == ST_IDLE);
    assign steps_done = r_steps_done;

endmodule
`default_nettype wire

// File: tb/tb_stepper_ramp_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_stepper_ramp_axis
// Desc     : Self-checking bench: table of hand-computed ramp profiles,
//            randomized commands against a period-profile model, and
//            hand sequences for abort, pause, reset and ignored commands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stepper_ramp_axis;

    localparam int STEP_W    = 16;
    localparam int PER_W     = 24;
    localparam int MIN_PULSE = 50;
    localparam int SETUP_CYC = 10;
    localparam int BUDGET    = 20000;

    logic              clk_50 = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_dir;
    logic [PER_W-1:0]  cmd_start_per;
    logic [PER_W-1:0]  cmd_cruise_per;
    logic [PER_W-1:0]  cmd_accel;
    logic              enable;
    logic              abort;
    logic              step;
    logic              dir;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_done;

    stepper_ramp_axis #(
        .STEP_W    (STEP_W),
        .PER_W     (PER_W),
        .MIN_PULSE (MIN_PULSE),
        .SETUP_CYC (SETUP_CYC)
    ) dut (
        .clk_50         (clk_50),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_steps      (cmd_steps),
        .cmd_dir        (cmd_dir),
        .cmd_start_per  (cmd_start_per),
        .cmd_cruise_per (cmd_cruise_per),
        .cmd_accel      (cmd_accel),
        .enable         (enable),
        .abort          (abort),
        .step           (step),
        .dir            (dir),
        .busy           (busy),
        .done           (done),
        .steps_done     (steps_done)
    );

    always #10 clk_50 = ~clk_50;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk_50) cyc++;

    // Pulse monitor, sampled on the falling edge
    int rise_q[$];
    int high_q[$];
    int done_q[$];
    int done_sd;
    int first_dir;
    logic prev_step = 1'b0;

    always @(negedge clk_50) begin
        if (reset_n) begin
            if (step && !prev_step) begin
                rise_q.push_back(cyc);
                if (rise_q.size() == 1) first_dir = int'(dir);
            end
            if (!step && prev_step && rise_q.size() > 0) high_q.push_back(cyc - rise_q[$]);
            if (done) begin
                done_q.push_back(cyc);
                done_sd = int'(steps_done);
            end
        end
        prev_step = step;
    end

    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected period list from the ramp rules, in plain integer arithmetic
    task automatic model_profile(input int n, input int st, input int cr, input int ac);
        int c, s, cur, ramp, rem;
        bit cruising, decel;
        c = imax(cr, 2 * MIN_PULSE);
        s = imax(imax(st, 2 * MIN_PULSE), c);
        cur = s; ramp = 0; cruising = 0; decel = 0;
        exp_q = {};
        for (int k = 1; k <= n; k++) begin
            exp_q.push_back(cur);
            rem = n - k;
            if (!decel) begin
                if (!cruising) ramp++;
                if (rem <= ramp) begin
                    decel = 1;
                    cur = imin(cur + ac, s);
                end else if (!cruising) begin
                    cur = imax(cur - ac, c);
                    if (cur == c) cruising = 1;
                end
            end else begin
                cur = imin(cur + ac, s);
            end
        end
    endtask

    task automatic clear_mon();
        rise_q = {};
        high_q = {};
        done_q = {};
        done_sd = -1;
        first_dir = -1;
    endtask

    task automatic run_cmd(input int n, input int st, input int cr, input int ac,
                           input bit d, output int acc);
        @(negedge clk_50);
        clear_mon();
        cmd_steps      = STEP_W'(n);
        cmd_start_per  = PER_W'(st);
        cmd_cruise_per = PER_W'(cr);
        cmd_accel      = PER_W'(ac);
        cmd_dir        = d;
        cmd_valid      = 1'b1;
        acc = cyc + 1;
        @(negedge clk_50);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_q.size() == 0 && k < BUDGET) begin
            @(negedge clk_50);
            k++;
        end
        if (done_q.size() == 0) chk({tag, " done timeout"}, 0, 1);
    endtask

    task automatic wait_rises(input string tag, input int n);
        int k = 0;
        while (rise_q.size() < n && k < BUDGET) begin
            @(negedge clk_50);
            k++;
        end
        if (rise_q.size() < n) chk({tag, " rise timeout"}, rise_q.size(), n);
    endtask

    // Compare a completed motion against exp_q
    task automatic check_run(input string tag, input int acc, input bit d);
        int n, pend;
        n = exp_q.size();
        wait_done(tag);
        repeat (4) @(negedge clk_50);
        chk({tag, " pulses"}, rise_q.size(), n);
        chk({tag, " done count"}, done_q.size(), 1);
        chk({tag, " steps_done"}, done_sd, n);
        chk({tag, " dir"}, int'(dir), int'(d));
        chk({tag, " busy after"}, int'(busy), 0);
        if (n == 0) begin
            if (done_q.size() > 0) chk({tag, " setup to done"}, done_q[0] - acc, SETUP_CYC);
        end else if (rise_q.size() > 0) begin
            chk({tag, " setup latency"}, rise_q[0] - acc, SETUP_CYC);
            chk({tag, " dir at step"}, first_dir, int'(d));
        end
        for (int i = 0; i < n && i < rise_q.size(); i++) begin
            pend = (i + 1 < rise_q.size()) ? rise_q[i + 1] : ((done_q.size() > 0) ? done_q[0] : 0);
            chk($sformatf("%s period[%0d]", tag, i), pend - rise_q[i], exp_q[i]);
            if (i < high_q.size())
                chk($sformatf("%s high[%0d]", tag, i), high_q[i], imax(exp_q[i] >> 1, MIN_PULSE));
        end
    endtask

    typedef struct {
        int steps;
        int start;
        int cruise;
        int accel;
        bit d;
        int nper;
        int per[10];
    } vec_t;

    vec_t tbl[7];

    initial begin
        int acc;
        int rn, rs, rc, ra;
        bit rd;

        tbl[0] = '{steps:4, start:1000, cruise:1000, accel:0, d:1'b1, nper:4,
                   per:'{1000, 1000, 1000, 1000, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{steps:10, start:1000, cruise:400, accel:200, d:1'b0, nper:10,
                   per:'{1000, 800, 600, 400, 400, 400, 400, 600, 800, 1000}};
        tbl[2] = '{steps:3, start:1000, cruise:400, accel:200, d:1'b1, nper:3,
                   per:'{1000, 800, 1000, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{steps:0, start:1000, cruise:400, accel:200, d:1'b1, nper:0,
                   per:'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[4] = '{steps:2, start:30, cruise:20, accel:7, d:1'b0, nper:2,
                   per:'{100, 100, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[5] = '{steps:3, start:300, cruise:500, accel:50, d:1'b1, nper:3,
                   per:'{500, 500, 500, 0, 0, 0, 0, 0, 0, 0}};
        tbl[6] = '{steps:6, start:1000, cruise:400, accel:350, d:1'b0, nper:6,
                   per:'{1000, 650, 400, 400, 750, 1000, 0, 0, 0, 0}};

        reset_n        = 1'b0;
        cmd_valid      = 1'b0;
        cmd_steps      = '0;
        cmd_dir        = 1'b0;
        cmd_start_per  = '0;
        cmd_cruise_per = '0;
        cmd_accel      = '0;
        enable         = 1'b1;
        abort          = 1'b0;
        clear_mon();

        repeat (3) @(negedge clk_50);
        chk("reset step", int'(step), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset steps_done", int'(steps_done), 0);
        chk("reset dir", int'(dir), 0);
        reset_n = 1'b1;
        @(negedge clk_50);
        chk("reset cmd_ready", int'(cmd_ready), 1);

        // Table-driven profiles
        for (int t = 0; t < 7; t++) begin
            exp_q = {};
            for (int i = 0; i < tbl[t].nper; i++) exp_q.push_back(tbl[t].per[i]);
            run_cmd(tbl[t].steps, tbl[t].start, tbl[t].cruise, tbl[t].accel, tbl[t].d, acc);
            check_run($sformatf("tbl%0d", t), acc, tbl[t].d);
        end

        // Randomized commands against the profile model
        for (int r = 0; r < 6; r++) begin
            rn = int'($urandom_range(0, 6));
            rs = int'($urandom_range(60, 900));
            rc = int'($urandom_range(60, 700));
            ra = int'($urandom_range(0, 300));
            rd = 1'($urandom_range(0, 1));
            model_profile(rn, rs, rc, ra);
            run_cmd(rn, rs, rc, ra, rd, acc);
            check_run($sformatf("rnd%0d", r), acc, rd);
        end

        // Abort in the 3rd pulse's high time; a new command offered mid-run is ignored
        run_cmd(10, 1000, 1000, 0, 1'b1, acc);
        wait_rises("abort", 1);
        cmd_steps = 16'd2; cmd_start_per = 24'd200; cmd_cruise_per = 24'd200;
        cmd_valid = 1'b1;
        repeat (5) @(negedge clk_50);
        cmd_valid = 1'b0;
        wait_rises("abort", 3);
        repeat (100) @(negedge clk_50);
        abort = 1'b1;
        @(negedge clk_50);
        abort = 1'b0;
        wait_done("abort");
        repeat (6) @(negedge clk_50);
        chk("abort pulses", rise_q.size(), 3);
        chk("abort steps_done", done_sd, 3);
        chk("abort done count", done_q.size(), 1);
        chk("abort busy after", int'(busy), 0);
        if (high_q.size() >= 3) chk("abort last high", high_q[2], 500);
        if (rise_q.size() >= 3 && done_q.size() > 0)
            chk("abort last period", done_q[0] - rise_q[2], 1000);

        // Abort while in setup: straight to done, no pulses
        run_cmd(5, 1000, 400, 200, 1'b0, acc);
        abort = 1'b1;
        @(negedge clk_50);
        abort = 1'b0;
        wait_done("setup abort");
        repeat (4) @(negedge clk_50);
        chk("setup abort pulses", rise_q.size(), 0);
        chk("setup abort steps_done", done_sd, 0);
        if (done_q.size() > 0) chk("setup abort latency", done_q[0] - acc, 1);

        // Reset mid-pulse drops step at once and nothing resumes
        run_cmd(4, 1000, 1000, 0, 1'b1, acc);
        wait_rises("reset", 1);
        repeat (100) @(negedge clk_50);
        chk("pre-reset step", int'(step), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async reset step", int'(step), 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset dir", int'(dir), 0);
        chk("async reset steps_done", int'(steps_done), 0);
        repeat (3) @(negedge clk_50);
        reset_n = 1'b1;
        clear_mon();
        repeat (50) @(negedge clk_50);
        chk("post-reset rises", rise_q.size(), 0);
        chk("post-reset cmd_ready", int'(cmd_ready), 1);

        // Pause for 200 cycles inside the first pulse's high time
        run_cmd(2, 1000, 1000, 0, 1'b0, acc);
        wait_rises("pause", 1);
        repeat (100) @(negedge clk_50);
        enable = 1'b0;
        @(negedge clk_50);
        chk("pause step held a", int'(step), 1);
        repeat (199) @(negedge clk_50);
        chk("pause step held b", int'(step), 1);
        enable = 1'b1;
        wait_done("pause");
        repeat (4) @(negedge clk_50);
        chk("pause pulses", rise_q.size(), 2);
        chk("pause steps_done", done_sd, 2);
        if (high_q.size() >= 1) chk("pause stretched high", high_q[0], 700);
        if (rise_q.size() >= 2) chk("pause stretched period", rise_q[1] - rise_q[0], 1200);
        if (rise_q.size() >= 2 && done_q.size() > 0)
            chk("pause next period", done_q[0] - rise_q[1], 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
